// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Pulls words out of a synchronous FIFO (one-cycle read latency) and
// presents them on a valid/ready stream through a 2-entry skid buffer.
// Reads are only requested when the buffer is guaranteed to have room
// for the returning word, so nothing is ever dropped or overwritten.
//
// Optional feature: define FIFO_RD_LAST_EN to build the burst counter
// that drives m_last every BURST_LEN beats. Without it m_last is tied
// low and BURST_LEN has no effect on the logic.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  // Buffer occupancy encoding; code 2'd3 is never entered and recovers to empty.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  // Elaboration-time guard on the burst length range.
  if (BURST_LEN < 2 || BURST_LEN > 256) begin : g_bad_burst_len
    $error("fifo_stream_reader: BURST_LEN must be within 2..256");
  end

  logic [1:0]            occ_r;
  logic [1:0]            occ_nxt_s;
  logic                  pend_r;
  logic                  run_r;
  logic [DATA_WIDTH-1:0] buf0_r;
  logic [DATA_WIDTH-1:0] buf1_r;
  logic [DATA_WIDTH-1:0] buf0_nxt_s;
  logic [DATA_WIDTH-1:0] buf1_nxt_s;
  logic                  pop_s;
  logic                  capture_s;
  logic                  rd_en_s;
  logic [2:0]            credit_s;

  // Read request: occupancy plus the word in flight, less this cycle's pop,
  // must leave room for one more word. run_r holds reads off until the first
  // clock edge after reset release.
  always_comb begin
    pop_s     = (occ_r != S_EMPTY) & m_ready;
    credit_s  = {1'b0, occ_r} + {2'b00, pend_r} - {2'b00, pop_s};
    capture_s = pend_r & ~flush;
    if (run_r && en && !fifo_empty && !flush && (credit_s < 3'd2)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Next buffer contents: buf0 is always the head beat, buf1 the one behind it.
  always_comb begin
    occ_nxt_s  = occ_r;
    buf0_nxt_s = buf0_r;
    buf1_nxt_s = buf1_r;
    if (flush) begin
      occ_nxt_s = S_EMPTY;
    end else begin
      case (occ_r)
        S_EMPTY: begin
          if (capture_s) begin
            buf0_nxt_s = fifo_rd_data;
            occ_nxt_s  = S_ONE;
          end else begin
            occ_nxt_s  = S_EMPTY;
          end
        end
        S_ONE: begin
          if (capture_s && pop_s) begin
            // Head leaves while the new word takes its place.
            buf0_nxt_s = fifo_rd_data;
            occ_nxt_s  = S_ONE;
          end else if (capture_s) begin
            buf1_nxt_s = fifo_rd_data;
            occ_nxt_s  = S_TWO;
          end else if (pop_s) begin
            occ_nxt_s  = S_EMPTY;
          end else begin
            occ_nxt_s  = S_ONE;
          end
        end
        S_TWO: begin
          if (pop_s) begin
            buf0_nxt_s = buf1_r;
            if (capture_s) begin
              buf1_nxt_s = fifo_rd_data;
              occ_nxt_s  = S_TWO;
            end else begin
              occ_nxt_s  = S_ONE;
            end
          end else begin
            // A capture cannot arrive here without a pop: no read was
            // issued while the buffer was already fully committed.
            occ_nxt_s = S_TWO;
          end
        end
        default: begin
          occ_nxt_s = S_EMPTY;
        end
      endcase
    end
  end

  // Buffer, occupancy, in-flight read flag and post-reset read gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r  <= S_EMPTY;
      pend_r <= 1'b0;
      run_r  <= 1'b0;
      buf0_r <= {DATA_WIDTH{1'b0}};
      buf1_r <= {DATA_WIDTH{1'b0}};
    end else begin
      occ_r  <= occ_nxt_s;
      pend_r <= rd_en_s;
      run_r  <= 1'b1;
      buf0_r <= buf0_nxt_s;
      buf1_r <= buf1_nxt_s;
    end
  end

  assign fifo_rd_en = rd_en_s;
  assign m_valid    = (occ_r != S_EMPTY);
  assign m_data     = buf0_r;

`ifdef FIFO_RD_LAST_EN
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  logic [CNT_W-1:0] cnt_r;

  // Burst beat counter: advances on every transfer, wraps after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (pop_s) begin
      if (cnt_r == LAST_CNT) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign m_last = (occ_r != S_EMPTY) && (cnt_r == LAST_CNT);
`else
  assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader. A queue models the upstream
// FIFO; every word pushed also goes to an expected-beat queue that is
// compared against each stream transfer. Flush and reset resynchronise the
// expectation to whatever the FIFO still holds.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BL = 4;
`ifdef FIFO_RD_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          flush;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
  );

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rd_count = 0;
  int pop_count = 0;
  int beat_idx = 0;
  int first_pop_cyc = -1;
  int last_pop_cyc = -1;
  bit hold_chk = 1'b0;
  logic [DW-1:0] hold_data;
  logic hold_last;

  task automatic push(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic resync();
    exp_q = fifo_q;
    beat_idx = 0;
    hold_chk = 1'b0;
  endtask

  // One clock cycle: check outputs just after the falling edge, then let
  // the FIFO model answer any read accepted at the rising edge.
  task automatic tick();
    bit acc;
    bit pop;
    logic [DW-1:0] exp_d;
    bit exp_l;
    #1;
    if (hold_chk) begin
      vectors++;
      if (m_valid !== 1'b1 || m_data !== hold_data || m_last !== hold_last) begin
        miscompares++;
        $display("FAIL hold_stable: valid=%b data=%0h last=%b, required valid=1 data=%0h last=%b",
                 m_valid, m_data, m_last, hold_data, hold_last);
      end
    end
    if (fifo_empty) begin
      vectors++;
      if (fifo_rd_en !== 1'b0) begin
        miscompares++;
        $display("FAIL rd_while_empty: fifo_rd_en=%b, required 0", fifo_rd_en);
      end
    end
    acc = (fifo_rd_en === 1'b1) && !fifo_empty;
    pop = (m_valid === 1'b1) && m_ready;
    if (acc) rd_count++;
    if (pop) begin
      pop_count++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL beat_unexpected: got data %0h, required no beat", m_data);
      end else begin
        exp_d = exp_q.pop_front();
        exp_l = LAST_EN && (beat_idx == BL - 1);
        if (m_data !== exp_d || m_last !== exp_l) begin
          miscompares++;
          $display("FAIL beat: got data %0h last %b, required data %0h last %b",
                   m_data, m_last, exp_d, exp_l);
        end
        beat_idx = (beat_idx + 1) % BL;
      end
    end
    hold_chk  = (m_valid === 1'b1) && !m_ready && !flush && rst_n;
    hold_data = m_data;
    hold_last = m_last;
    @(posedge clk);
    #1;
    if (acc && rst_n) begin
      fifo_rd_data = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: %0d beats outstanding, m_valid=%b, required 0 and 0",
               exp_q.size(), m_valid);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    resync();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    m_ready = 1'b0;
    push(8'hA0);
    push(8'hA1);
    @(negedge clk);
    #1;
    vectors++;
    if (fifo_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rd_en: got %b, required 0", fifo_rd_en);
    end
    vectors++;
    if (m_valid !== 1'b0 || m_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid_last: got %b %b, required 0 0", m_valid, m_last);
    end
    vectors++;
    if (m_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: got %0h, required 0", m_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (fifo_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL release_rd_en: got %b, required 0 before first edge", fifo_rd_en);
    end
    drain(20);
  endtask

  task automatic test_stream();
    int start;
    do_flush();
    pop_count = 0;
    first_pop_cyc = -1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    en = 1'b1;
    m_ready = 1'b1;
    start = cyc;
    repeat (12) tick();
    vectors++;
    if (pop_count != 8 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stream_count: got %0d beats, required 8", pop_count);
    end
    vectors++;
    if (first_pop_cyc - start < 1 || first_pop_cyc - start > 2) begin
      miscompares++;
      $display("FAIL stream_latency: got %0d cycles, required 1..2", first_pop_cyc - start);
    end
    vectors++;
    if (last_pop_cyc - first_pop_cyc != 7) begin
      miscompares++;
      $display("FAIL stream_back_to_back: span %0d cycles, required 7", last_pop_cyc - first_pop_cyc);
    end
  endtask

  task automatic test_backpressure();
    do_flush();
    m_ready = 1'b0;
    en = 1'b1;
    rd_count = 0;
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
    repeat (5) tick();
    vectors++;
    if (rd_count != 2) begin
      miscompares++;
      $display("FAIL bp_reads: got %0d reads, required 2", rd_count);
    end
    vectors++;
    if (m_valid !== 1'b1 || m_data !== 8'h20) begin
      miscompares++;
      $display("FAIL bp_head: got valid %b data %0h, required 1 20", m_valid, m_data);
    end
    drain(30);
    vectors++;
    if (rd_count != 6) begin
      miscompares++;
      $display("FAIL bp_total_reads: got %0d, required 6", rd_count);
    end
  endtask

  task automatic test_toggle();
    do_flush();
    pop_count = 0;
    en = 1'b1;
    for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
    for (int i = 0; i < 12; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    vectors++;
    if (pop_count != 3 || exp_q.size() != 0 || fifo_q.size() != 0) begin
      miscompares++;
      $display("FAIL toggle_beats: got %0d beats, required 3", pop_count);
    end
  endtask

  task automatic test_flush();
    do_flush();
    m_ready = 1'b0;
    en = 1'b1;
    rd_count = 0;
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    repeat (4) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    vectors++;
    if (m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_valid: got %b, required 0", m_valid);
    end
    vectors++;
    if (rd_count != 3 || fifo_q.size() != 5) begin
      miscompares++;
      $display("FAIL flush_reads: got %0d reads, required 3", rd_count);
    end
    resync();
    drain(30);
  endtask

  task automatic test_reset_mid();
    do_flush();
    m_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || fifo_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_ctrl: got valid %b last %b rd %b, required 0 0 0",
               m_valid, m_last, fifo_rd_en);
    end
    vectors++;
    if (m_data !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset_data: got %0h, required 0", m_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    resync();
    vectors++;
    if (fifo_q.size() != 6) begin
      miscompares++;
      $display("FAIL reset_fifo_head: got %0d words left, required 6", fifo_q.size());
    end
    drain(30);
  endtask

  task automatic test_en_drop();
    int rd0;
    int pc0;
    do_flush();
    rd_count = 0;
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(8'h60 + 8'(i));
    repeat (4) tick();
    en = 1'b0;
    rd0 = rd_count;
    pc0 = pop_count;
    repeat (3) tick();
    vectors++;
    if (rd_count != rd0) begin
      miscompares++;
      $display("FAIL en_drop_reads: got %0d new reads, required 0", rd_count - rd0);
    end
    vectors++;
    if (pop_count - pc0 != 2 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL en_drop_drain: got %0d beats valid %b, required 2 beats valid 0",
               pop_count - pc0, m_valid);
    end
    en = 1'b1;
    #1;
    vectors++;
    if (fifo_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL en_resume: got fifo_rd_en %b, required 1", fifo_rd_en);
    end
    drain(40);
    vectors++;
    if (rd_count != 10) begin
      miscompares++;
      $display("FAIL en_total_reads: got %0d, required 10", rd_count);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    flush = 1'b0;
    m_ready = 1'b0;
    fifo_empty = 1'b1;
    fifo_rd_data = 8'h00;
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_flush();
    test_reset_mid();
    test_en_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
